// File: rtl/crc24_frame_tx_if.sv
// Byte-stream handshake feeding the CRC-24 frame serializer.
`default_nettype none

interface crc24_frame_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

`default_nettype wire

// File: rtl/crc24_frame_tx.sv
// Serializes payload bytes MSB-first at the line bit strobe and appends an
// in-line computed CRC-24 (poly 0x864CFB) trailer, MSB-first.
`default_nettype none

module crc24_frame_tx #(
    parameter logic [23:0] CRC_INIT = 24'h000000
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             bit_en_i,
    crc24_frame_tx_if.slave       s_if,
    output logic                  tx_bit_o,
    output logic                  tx_valid_o,
    output logic                  tx_crc_o,
    output logic                  tx_eof_o,
    output logic                  frame_done_o,
    output logic                  underrun_o,
    output logic [23:0]           crc_value_o
);

    localparam logic [23:0] POLY = 24'h864CFB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] crc_q, crc_d;
    logic [23:0] crc_sh_q, crc_sh_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        last_q, last_d;
    logic [23:0] crc_value_q, crc_value_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic        s_ready;
    logic [23:0] crc_step;

    // CRC advanced by the payload bit currently on the line.
    assign crc_step = {crc_q[22:0], 1'b0} ^ ((crc_q[23] ^ shreg_q[7]) ? POLY : 24'h000000);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            crc_sh_q     <= 24'h000000;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 5'd0;
            last_q       <= 1'b0;
            crc_value_q  <= 24'h000000;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            crc_sh_q     <= crc_sh_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            last_q       <= last_d;
            crc_value_q  <= crc_value_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        crc_sh_d     = crc_sh_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        last_d       = last_q;
        crc_value_d  = crc_value_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        s_ready      = 1'b0;
        tx_bit_o     = 1'b0;
        tx_valid_o   = 1'b0;
        tx_crc_o     = 1'b0;
        tx_eof_o     = 1'b0;

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_if.s_valid) begin
                    shreg_d   = s_if.s_data;
                    last_d    = s_if.s_last;
                    bit_cnt_d = 5'd0;
                    crc_d     = CRC_INIT;
                    state_d   = DATA;
                end
            end

            DATA: begin
                tx_bit_o   = shreg_q[7];
                tx_valid_o = 1'b1;
                if (bit_en_i) begin
                    crc_d     = crc_step;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        if (!last_q) begin
                            // Next byte must be waiting now; there is no gap bit.
                            s_ready = 1'b1;
                            if (s_if.s_valid) begin
                                shreg_d = s_if.s_data;
                                last_d  = s_if.s_last;
                            end else begin
                                underrun_d = 1'b1;
                                crc_d      = CRC_INIT;
                                state_d    = IDLE;
                            end
                        end else begin
                            crc_sh_d = crc_step;
                            state_d  = CRC;
                        end
                    end
                end
            end

            CRC: begin
                tx_bit_o   = crc_sh_q[23];
                tx_valid_o = 1'b1;
                tx_crc_o   = 1'b1;
                tx_eof_o   = (bit_cnt_q == 5'd23);
                if (bit_en_i) begin
                    crc_sh_d  = {crc_sh_q[22:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        crc_value_d  = crc_q;
                        frame_done_d = 1'b1;
                        bit_cnt_d    = 5'd0;
                        state_d      = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_if.s_ready = s_ready;
    assign frame_done_o = frame_done_q;
    assign underrun_o   = underrun_q;
    assign crc_value_o  = crc_value_q;

endmodule

`default_nettype wire
